// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: FSM states, funct3
// encodings and the access legality check used when a request is accepted.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // 1 when funct3 is a legal size for the direction and the address is
    // naturally aligned for that size. Unsigned variants exist only for loads.
    function automatic logic access_ok(input logic       is_write,
                                       input logic [2:0] funct3,
                                       input logic [1:0] addr_lo);
        logic ok;
        ok = 1'b0;
        case (funct3)
            F3_B:    ok = 1'b1;
            F3_BU:   ok = !is_write;
            F3_H:    ok = !addr_lo[0];
            F3_HU:   ok = !is_write && !addr_lo[0];
            F3_W:    ok = (addr_lo == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Valid/ready data bus between the load/store unit (master) and a memory
// slave. Read responses come back on a separate rsp_valid strobe.
interface lsu_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic                  req_we;
    logic [3:0]            req_be;
    logic [31:0]           req_wdata;
    logic                  rsp_valid;
    logic [31:0]           rsp_rdata;
    logic                  rsp_err;

    modport master (
        output req_valid, req_addr, req_we, req_be, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_addr, req_we, req_be, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/lsu_align.sv
// Byte-lane formatting: byte enables and lane-replicated store data for the
// bus, and lane selection plus sign/zero extension for returning loads.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    input  logic [31:0] wdata,
    input  logic [31:0] rsp_rdata,
    output logic [3:0]  be,
    output logic [31:0] store_data,
    output logic [31:0] load_data
);
    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;

    // Lane selection and formatting; funct3[1:0] alone decides the access size
    always_comb begin
        byte_s = rsp_rdata[{addr_lo, 3'b000} +: 8];
        half_s = rsp_rdata[{addr_lo[1], 4'b0000} +: 16];

        case (funct3[1:0])
            2'b00: begin
                be         = 4'b0001 << addr_lo;
                store_data = {4{wdata[7:0]}};
            end
            2'b01: begin
                be         = 4'b0011 << addr_lo;
                store_data = {2{wdata[15:0]}};
            end
            default: begin
                be         = 4'hF;
                store_data = wdata;
            end
        endcase

        case (funct3)
            F3_B:    load_data = 32'(byte_s);
            F3_H:    load_data = 32'(half_s);
            F3_BU:   load_data = {24'd0, byte_s};
            F3_HU:   load_data = {16'd0, half_s};
            default: load_data = rsp_rdata;
        endcase
    end
endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns the core's single-cycle memory request into a
// valid/ready bus transaction, stalls the core until it completes and
// returns formatted load data with a one-cycle done pulse.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [2:0]            funct3,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata,
    output logic                  stall,
    output logic                  done,
    output logic                  access_err,
    output logic                  bus_err,
    lsu_if.master                 bus
);
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TO_LAST =
        CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    lsu_state_e            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [2:0]            funct3_q;
    logic [31:0]           wdata_q;
    logic                  we_q;
    logic [31:0]           rdata_q;
    logic                  bus_err_q;

    logic                  start;
    logic                  resp_take;
    logic                  timeout_exit;
    logic                  timeout_hit;
    logic [3:0]            be;
    logic [31:0]           store_data;
    logic [31:0]           load_data;

    lsu_align u_align (
        .addr_lo   (addr_q[1:0]),
        .funct3    (funct3_q),
        .wdata     (wdata_q),
        .rsp_rdata (bus.rsp_rdata),
        .be        (be),
        .store_data(store_data),
        .load_data (load_data)
    );

    // The counter value TO_LAST marks the final allowed cycle in REQ/RESP
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST);

    // Next state, stall and access-error decode; stall/access_err forced low in reset
    always_comb begin
        state_d      = state_q;
        stall        = 1'b0;
        access_err   = 1'b0;
        start        = 1'b0;
        resp_take    = 1'b0;
        timeout_exit = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_read || mem_write) begin
                    if (access_ok(mem_write, funct3, addr[1:0])) begin
                        start   = 1'b1;
                        stall   = 1'b1;
                        state_d = REQ;
                    end else begin
                        access_err = 1'b1;
                    end
                end
            end
            REQ: begin
                stall = 1'b1;
                if (bus.req_ready) begin
                    state_d = we_q ? DONE : RESP;
                end else if (timeout_hit) begin
                    timeout_exit = 1'b1;
                    state_d      = DONE;
                end
            end
            RESP: begin
                stall = 1'b1;
                if (bus.rsp_valid) begin
                    resp_take = 1'b1;
                    state_d   = DONE;
                end else if (timeout_hit) begin
                    timeout_exit = 1'b1;
                    state_d      = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (!reset) begin
            stall      = 1'b0;
            access_err = 1'b0;
        end
    end

    // State register; the wait counter restarts on every state change
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_d != state_q) begin
                cnt_q <= '0;
            end else if (state_q == REQ || state_q == RESP) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    // Request direction, held for the whole access
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            we_q <= 1'b0;
        end else if (start) begin
            we_q <= mem_write;
        end
    end

    // Request payload latch; only observed while the request is outstanding
    always_ff @(posedge clk) begin
        if (start) begin
            addr_q   <= addr;
            funct3_q <= funct3;
            wdata_q  <= wdata;
        end
    end

    // Completion results, captured on the transition into DONE and held
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_q   <= '0;
            bus_err_q <= 1'b0;
        end else if (state_q != DONE && state_d == DONE) begin
            rdata_q   <= resp_take ? load_data : '0;
            bus_err_q <= resp_take ? bus.rsp_err : timeout_exit;
        end
    end

    assign bus.req_valid = (state_q == REQ);
    assign bus.req_addr  = bus.req_valid ? {addr_q[ADDR_WIDTH-1:2], 2'b00} : '0;
    assign bus.req_we    = bus.req_valid & we_q;
    assign bus.req_be    = bus.req_valid ? be : 4'h0;
    assign bus.req_wdata = (bus.req_valid && we_q) ? store_data : '0;

    assign done    = (state_q == DONE);
    assign bus_err = done & bus_err_q;
    assign rdata   = rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a vector table of single accesses plus
// hand-written sequences for early responses, slave errors, timeout and reset.
module tb_load_store_unit;
    import lsu_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    // Main unit, default timeout
    logic        mem_read, mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata, rdata;
    logic        stall, done, access_err, bus_err;
    lsu_if #(.ADDR_WIDTH(32)) bus ();

    load_store_unit #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(255)) dut (
        .clk(clk), .reset(reset),
        .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3),
        .addr(addr), .wdata(wdata), .rdata(rdata), .stall(stall),
        .done(done), .access_err(access_err), .bus_err(bus_err), .bus(bus)
    );

    // Second unit with a short timeout
    logic        t_mem_read, t_mem_write;
    logic [2:0]  t_funct3;
    logic [31:0] t_addr, t_wdata, t_rdata;
    logic        t_stall, t_done, t_access_err, t_bus_err;
    lsu_if #(.ADDR_WIDTH(32)) bus_t ();

    load_store_unit #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(4)) dut_to (
        .clk(clk), .reset(reset),
        .mem_read(t_mem_read), .mem_write(t_mem_write), .funct3(t_funct3),
        .addr(t_addr), .wdata(t_wdata), .rdata(t_rdata), .stall(t_stall),
        .done(t_done), .access_err(t_access_err), .bus_err(t_bus_err), .bus(bus_t)
    );

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rsp;
        logic        aerr;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
        int          ready_delay;
    } vec_t;

    localparam int NVEC = 16;
    vec_t vecs[NVEC];

    int total  = 0;
    int passed = 0;

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s[%0d]: got 0x%08h expected 0x%08h", nm, idx, act, exp);
    endtask

    // Applies one vector starting at a negedge with the unit idle; returns at a negedge, idle again
    task automatic do_access(input vec_t v, input int idx);
        int stall_n;
        stall_n   = 0;
        mem_read  = !v.we;
        mem_write = v.we;
        funct3    = v.f3;
        addr      = v.addr;
        wdata     = v.wdata;
        #1;
        if (v.aerr) begin
            chk("access_err", idx, 32'(access_err), 32'd1);
            chk("aerr_stall", idx, 32'(stall), 32'd0);
            @(negedge clk);
            chk("aerr_no_req", idx, 32'(bus.req_valid), 32'd0);
            mem_read  = 1'b0;
            mem_write = 1'b0;
            #1;
            chk("aerr_clear", idx, 32'(access_err), 32'd0);
            @(negedge clk);
            return;
        end
        chk("idle_stall", idx, 32'(stall), 32'd1);
        stall_n += int'(stall);
        @(negedge clk);
        for (int c = 0; c <= v.ready_delay; c++) begin
            chk("req_valid", idx, 32'(bus.req_valid), 32'd1);
            chk("req_addr", idx, bus.req_addr, v.exp_addr);
            chk("req_be", idx, 32'(bus.req_be), 32'(v.exp_be));
            chk("req_wdata", idx, bus.req_wdata, v.exp_wdata);
            chk("req_we", idx, 32'(bus.req_we), 32'(v.we));
            stall_n += int'(stall);
            bus.req_ready = (c == v.ready_delay);
            @(negedge clk);
        end
        bus.req_ready = 1'b0;
        if (!v.we) begin
            chk("resp_done_low", idx, 32'(done), 32'd0);
            stall_n += int'(stall);
            bus.rsp_valid = 1'b1;
            bus.rsp_rdata = v.rsp;
            bus.rsp_err   = 1'b0;
            @(negedge clk);
            bus.rsp_valid = 1'b0;
            bus.rsp_rdata = 32'd0;
        end
        chk("done", idx, 32'(done), 32'd1);
        chk("done_stall", idx, 32'(stall), 32'd0);
        chk("done_bus_err", idx, 32'(bus_err), 32'd0);
        if (!v.we) chk("rdata", idx, rdata, v.exp_rdata);
        chk("stall_cycles", idx, stall_n, (v.we ? 2 : 3) + v.ready_delay);
        mem_read  = 1'b0;
        mem_write = 1'b0;
        @(negedge clk);
        chk("done_pulse", idx, 32'(done), 32'd0);
        chk("req_idle", idx, 32'(bus.req_valid), 32'd0);
    endtask

    initial begin
        int waited;

        //          we    f3     addr         wdata         rsp           aerr  exp_addr      be       exp_wdata     exp_rdata     dly
        vecs[0]  = '{1'b0, F3_W,  32'h100, 32'h0,        32'hDEADBEEF, 1'b0, 32'h100, 4'b1111, 32'h0,        32'hDEADBEEF, 0};
        vecs[1]  = '{1'b0, F3_B,  32'h103, 32'h0,        32'h80FF0000, 1'b0, 32'h100, 4'b1000, 32'h0,        32'hFFFFFF80, 0};
        vecs[2]  = '{1'b0, F3_BU, 32'h103, 32'h0,        32'h80FF0000, 1'b0, 32'h100, 4'b1000, 32'h0,        32'h00000080, 0};
        vecs[3]  = '{1'b1, F3_H,  32'h202, 32'h1234ABCD, 32'h0,        1'b0, 32'h200, 4'b1100, 32'hABCDABCD, 32'h0,        5};
        vecs[4]  = '{1'b0, F3_W,  32'h101, 32'h0,        32'h0,        1'b1, 32'h0,   4'b0000, 32'h0,        32'h0,        0};
        vecs[5]  = '{1'b1, F3_B,  32'h001, 32'h000000A5, 32'h0,        1'b0, 32'h000, 4'b0010, 32'hA5A5A5A5, 32'h0,        1};
        vecs[6]  = '{1'b1, F3_W,  32'h010, 32'hCAFEF00D, 32'h0,        1'b0, 32'h010, 4'b1111, 32'hCAFEF00D, 32'h0,        0};
        vecs[7]  = '{1'b0, F3_HU, 32'h002, 32'h0,        32'h80011234, 1'b0, 32'h000, 4'b1100, 32'h0,        32'h00008001, 0};
        vecs[8]  = '{1'b0, F3_H,  32'h002, 32'h0,        32'h80011234, 1'b0, 32'h000, 4'b1100, 32'h0,        32'hFFFF8001, 0};
        vecs[9]  = '{1'b0, F3_H,  32'h000, 32'h0,        32'h00007FFF, 1'b0, 32'h000, 4'b0011, 32'h0,        32'h00007FFF, 0};
        vecs[10] = '{1'b0, F3_B,  32'h101, 32'h0,        32'h00007F00, 1'b0, 32'h100, 4'b0010, 32'h0,        32'h0000007F, 0};
        vecs[11] = '{1'b0, 3'b011, 32'h000, 32'h0,       32'h0,        1'b1, 32'h0,   4'b0000, 32'h0,        32'h0,        0};
        vecs[12] = '{1'b1, 3'b100, 32'h000, 32'h0,       32'h0,        1'b1, 32'h0,   4'b0000, 32'h0,        32'h0,        0};
        vecs[13] = '{1'b1, F3_H,  32'h003, 32'h5555,     32'h0,        1'b1, 32'h0,   4'b0000, 32'h0,        32'h0,        0};
        vecs[14] = '{1'b0, F3_B,  32'h102, 32'h0,        32'h00800000, 1'b0, 32'h100, 4'b0100, 32'h0,        32'hFFFFFF80, 0};
        vecs[15] = '{1'b0, F3_W,  32'h102, 32'h0,        32'h0,        1'b1, 32'h0,   4'b0000, 32'h0,        32'h0,        0};

        reset         = 1'b0;
        mem_read      = 1'b1;
        mem_write     = 1'b0;
        funct3        = F3_W;
        addr          = 32'h0;
        wdata         = 32'h0;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.rsp_rdata = 32'h0;
        bus.rsp_err   = 1'b0;
        t_mem_read    = 1'b0;
        t_mem_write   = 1'b0;
        t_funct3      = F3_W;
        t_addr        = 32'h0;
        t_wdata       = 32'h0;
        bus_t.req_ready = 1'b0;
        bus_t.rsp_valid = 1'b0;
        bus_t.rsp_rdata = 32'h0;
        bus_t.rsp_err   = 1'b0;

        // Reset state, with a load request already presented
        @(negedge clk);
        @(negedge clk);
        chk("rst_stall", 0, 32'(stall), 32'd0);
        chk("rst_done", 0, 32'(done), 32'd0);
        chk("rst_access_err", 0, 32'(access_err), 32'd0);
        chk("rst_bus_err", 0, 32'(bus_err), 32'd0);
        chk("rst_rdata", 0, rdata, 32'd0);
        chk("rst_req_valid", 0, 32'(bus.req_valid), 32'd0);
        chk("rst_req_be", 0, 32'(bus.req_be), 32'd0);
        mem_read = 1'b0;
        reset    = 1'b1;
        @(negedge clk);

        for (int i = 0; i < NVEC; i++) begin
            do_access(vecs[i], i);
        end

        // A response in the handshake cycle must be ignored
        mem_read = 1'b1; funct3 = F3_W; addr = 32'h40;
        @(negedge clk);
        chk("early_req", 100, 32'(bus.req_valid), 32'd1);
        bus.req_ready = 1'b1;
        bus.rsp_valid = 1'b1;
        bus.rsp_rdata = 32'h11111111;
        @(negedge clk);
        bus.req_ready = 1'b0;
        chk("early_not_done", 100, 32'(done), 32'd0);
        chk("early_stall", 100, 32'(stall), 32'd1);
        bus.rsp_rdata = 32'h22222222;
        @(negedge clk);
        bus.rsp_valid = 1'b0;
        chk("early_done", 100, 32'(done), 32'd1);
        chk("early_rdata", 100, rdata, 32'h22222222);
        mem_read = 1'b0;
        @(negedge clk);

        // Slave error on a read response
        mem_read = 1'b1; funct3 = F3_W; addr = 32'h44;
        @(negedge clk);
        bus.req_ready = 1'b1;
        @(negedge clk);
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b1;
        bus.rsp_err   = 1'b1;
        bus.rsp_rdata = 32'h33333333;
        @(negedge clk);
        bus.rsp_valid = 1'b0;
        bus.rsp_err   = 1'b0;
        chk("rsp_err_done", 101, 32'(done), 32'd1);
        chk("rsp_err_bus_err", 101, 32'(bus_err), 32'd1);
        mem_read = 1'b0;
        @(negedge clk);
        chk("rsp_err_clear", 101, 32'(bus_err), 32'd0);

        // Read timeout in RESP on the short-timeout unit
        t_mem_read = 1'b1; t_funct3 = F3_H; t_addr = 32'h0;
        @(negedge clk);
        chk("to_req", 102, 32'(bus_t.req_valid), 32'd1);
        bus_t.req_ready = 1'b1;
        @(negedge clk);
        bus_t.req_ready = 1'b0;
        chk("to_resp_stall", 102, 32'(t_stall), 32'd1);
        chk("to_resp_req_low", 102, 32'(bus_t.req_valid), 32'd0);
        waited = 0;
        while (!t_done && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        chk("to_done", 102, 32'(t_done), 32'd1);
        chk("to_resp_cycles", 102, waited, 4);
        chk("to_bus_err", 102, 32'(t_bus_err), 32'd1);
        chk("to_rdata", 102, t_rdata, 32'd0);
        chk("to_stall", 102, 32'(t_stall), 32'd0);
        t_mem_read = 1'b0;
        @(negedge clk);
        chk("to_pulse", 102, 32'(t_bus_err), 32'd0);

        // Reset asserted with the request outstanding
        mem_read = 1'b1; funct3 = F3_W; addr = 32'h80;
        @(negedge clk);
        chk("mid_req_valid", 103, 32'(bus.req_valid), 32'd1);
        #1 reset = 1'b0;
        #1;
        chk("mid_rst_req_valid", 103, 32'(bus.req_valid), 32'd0);
        chk("mid_rst_stall", 103, 32'(stall), 32'd0);
        mem_read = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst_idle", 103, 32'(bus.req_valid), 32'd0);
        chk("post_rst_done", 103, 32'(done), 32'd0);
        do_access(vecs[0], 104);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    // Hard stop in case a sequence desynchronises from the unit
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits directly downstream of the single-cycle core's ALU/register-file read stage.
- Takes the core's memory request (ALU address, rs2 store data, funct3, read/write strobes) and drives a valid/ready data bus.
- Returns aligned, sign/zero-extended load data, and stalls the core (PC and register-file write held) until the access completes.
- Replaces the core's ideal zero-latency data memory so real bus slaves with wait states can be attached.

Parameters:
- ADDR_WIDTH, 32, byte address width on core and bus sides.
- TIMEOUT_CYCLES, 255, maximum cycles waiting in REQ or RESP before bus error; 0 disables the timeout.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- mem_read  input  1  core requests a load this cycle.
- mem_write  input  1  core requests a store this cycle; never asserted together with mem_read.
- funct3  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- addr  input  ADDR_WIDTH  byte address from the ALU.
- wdata  input  32  store data, right-aligned, from rs2.
- rdata  output  32  formatted load data; valid while done=1.
- stall  output  1  core must hold PC and suppress register/memory side effects.
- done  output  1  one-cycle pulse: access complete, core commits this cycle.
- access_err  output  1  one-cycle pulse: misaligned address or illegal funct3; no bus access made.
- bus_err  output  1  one-cycle pulse, coincident with done: rsp_err seen or timeout.
- req_valid  output  1  bus request valid.
- req_ready  input  1  slave accepts the request.
- req_addr  output  ADDR_WIDTH  word-aligned address; bits [1:0] are always 0.
- req_we  output  1  1 = write.
- req_be  output  4  byte enables.
- req_wdata  output  32  lane-replicated store data.
- rsp_valid  input  1  read response valid; ignored for writes.
- rsp_rdata  input  32  read response word.
- rsp_err  input  1  slave error, qualified by rsp_valid.

Behaviour:
- Reset (async, active-low):
  - State = IDLE, timeout counter = 0.
  - All outputs 0, including req_valid, which drops immediately even mid-handshake.
  - An access in flight when reset asserts is abandoned; no response is expected afterwards.
- FSM states: IDLE, REQ, RESP, DONE.
- IDLE:
  - On (mem_read | mem_write) with a legal, aligned access: latch addr, funct3, wdata and we; go to REQ. stall=1 combinationally in this same cycle.
  - On an illegal or misaligned access: access_err=1 and stall=0 for this cycle; stay in IDLE; no bus activity.
- Legality rules:
  - Illegal funct3: loads 011, 110, 111; stores anything above 010.
  - Misaligned: H/HU with addr[0]=1; W with addr[1:0]≠0.
- REQ:
  - req_valid=1 and stall=1.
  - req_addr, req_we, req_be and req_wdata are driven from latched values and stay stable until req_ready.
  - On req_valid & req_ready: a write goes to DONE, a read goes to RESP.
- RESP:
  - stall=1.
  - On rsp_valid: capture the formatted rsp_rdata into the rdata register and capture rsp_err; go to DONE.
  - A rsp_valid that arrives in the same cycle as the REQ handshake is not accepted; the response must come at least one cycle later.
- DONE:
  - stall=0 and done=1; rdata held valid.
  - Unconditionally return to IDLE. mem_read/mem_write are ignored in DONE because the core is still presenting the retiring instruction.
- Timeout:
  - The counter clears on entering REQ or RESP and increments in each cycle spent there.
  - If it reaches TIMEOUT_CYCLES (when nonzero) before the exit condition: go to DONE with bus_err=1 and rdata=0.
  - req_valid deasserts on that transition.
- Minimum latency: read = 4 cycles (stall high for 3); write = 3 cycles (stall high for 2).
- Store formatting:
  - SB: be = 4'b0001 << addr[1:0]; wdata[7:0] replicated on all 4 lanes.
  - SH: be = 4'b0011 << addr[1:0]; wdata[15:0] replicated on both halves.
  - SW: be = 4'hF; wdata passed through unchanged.
- Load formatting: select the byte/half lane by addr[1:0]; B/H sign-extend to 32 bits; BU/HU zero-extend; W passes through.
- For reads, req_be is set as for the equivalent store and req_wdata = 0.

Decomposition:
- lsu_pkg holds:
  - FSM state enum (IDLE, REQ, RESP, DONE);
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - a function that returns the legal/aligned flag.
- One combinational sub-module, lsu_align, owns lane formatting: inputs addr[1:0], funct3, wdata, rsp_rdata; outputs be, req_wdata and formatted load data.
- load_store_unit owns the FSM, latches and timeout counter.

Test Plan:
- LW at 0x100, req_ready=1, rsp_valid the cycle after the handshake with 0xDEADBEEF -> stall high 3 cycles; done with rdata=0xDEADBEEF; req_addr=0x100, be=4'hF.
- LB at 0x103 with response 0x80FF_0000 -> be=4'b1000, rdata=0xFFFFFF80. Same access as LBU -> rdata=0x00000080.
- SH at 0x202 with wdata 0x1234ABCD, req_ready held low 5 cycles -> req fields stable throughout; be=4'b1100, req_wdata=0xABCDABCD, req_we=1; done 1 cycle after the handshake.
- LW at 0x101 -> access_err pulses 1 cycle; stall=0; req_valid never asserts.
- LH at 0x000, TIMEOUT_CYCLES=4, rsp_valid never arrives -> after 4 cycles in RESP, done=1, bus_err=1, rdata=0.
- reset asserted while in REQ with req_valid=1 -> req_valid and stall drop asynchronously; after release the FSM is IDLE and a new LW completes normally.
